csr_trap_unit: RTL and testbench

Parametrised machine-mode CSR file and trap controller for the RV32 core; the next generation of the core's CSR block. Holds the M-mode CSRs, a 64-bit mtime counter, and a configurable bank of platform interrupt lines. Arbitrates exceptions and interrupts with fixed priority, handles `mret`, and presents the new PC to the fetch stage through a valid/ready redirect handshake. Sits beside the decode/execute stage; CSR reads are combinational and writes are registered.

---
 rtl/csr_trap_unit.sv | 233 +++++++++++++++++++++++
 tb/tb_csr_trap_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file with a 64-bit mtime counter, fixed-priority
// trap entry, mret handling and a valid/ready PC redirect toward the fetch stage.
// Build option: define CSR_COUNTERS_EN to add mcycle/minstret and the inst_retire input.
module csr_trap_unit #(
  parameter int          XLEN         = 32,
  parameter int          NUM_PLAT_IRQ = 4,
  parameter logic [31:0] HART_ID      = 32'h0000_0000,
  parameter logic [31:0] MTVEC_RESET  = 32'h0000_0000
) (
  input  logic                                        clk,
  input  logic                                        rst,
`ifdef CSR_COUNTERS_EN
  input  logic                                        inst_retire,
`endif
  input  logic [11:0]                                 csr_raddr,
  output logic [XLEN-1:0]                             csr_rdata,
  input  logic                                        csr_we,
  input  logic [11:0]                                 csr_waddr,
  input  logic [1:0]                                  csr_wop,
  input  logic [XLEN-1:0]                             csr_wdata,
  input  logic                                        exc_valid,
  input  logic [4:0]                                  exc_code,
  input  logic [XLEN-1:0]                             exc_pc,
  input  logic [XLEN-1:0]                             exc_tval,
  input  logic [XLEN-1:0]                             int_pc,
  input  logic                                        branch_hazard,
  input  logic                                        mret_valid,
  input  logic                                        meip,
  input  logic                                        msip,
  input  logic [((NUM_PLAT_IRQ > 0) ? NUM_PLAT_IRQ : 1)-1:0] plat_irq,
  input  logic [63:0]                                 mtimecmp,
  input  logic                                        time_tick,
  output logic [63:0]                                 mtime,
  output logic                                        redirect_valid,
  output logic [XLEN-1:0]                             redirect_pc,
  input  logic                                        redirect_ready
);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_REDIR = 1'b1} state_t;

  // Platform lines occupy mip/mie bits 16 upward; a zero-line build masks them all off.
  localparam logic [31:0] PLAT_MASK  = ((32'h1 << NUM_PLAT_IRQ) - 32'h1) << 16;
  localparam logic [31:0] MIE_MASK   = 32'h0000_0888 | PLAT_MASK;
  localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFD;
  localparam logic [31:0] MEPC_MASK  = 32'hFFFF_FFFC;
  localparam logic [31:0] MISA_VAL   = 32'h4000_0100;

  state_t      r_state;
  logic        r_mstatus_mie;
  logic        r_mstatus_mpie;
  logic [31:0] r_mie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;
  logic [31:0] r_redirect_pc;
  logic        r_redirect_valid;
  logic [63:0] r_mtime;
`ifdef CSR_COUNTERS_EN
  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;
`endif

  logic [31:0] w_mstatus;
  logic [31:0] w_mstatus_wv;
  logic [31:0] w_mip;
  logic [31:0] w_pend;
  logic [31:0] w_rdata;
  logic [31:0] w_trap_vec;
  logic        w_mtip;
  logic        w_irq_take;
  logic        w_trap;
  logic        w_mret;
  logic        w_wr_en;
  logic [4:0]  w_irq_cause;

  // Read-modify-write operand: 01 write, 10 set, 11 clear, 00 keeps the old value.
  function automatic logic [31:0] csr_wval(input logic [31:0] old_v,
                                           input logic [31:0] wd,
                                           input logic [1:0]  op);
    case (op)
      2'b01:   csr_wval = wd;
      2'b10:   csr_wval = old_v | wd;
      2'b11:   csr_wval = old_v & ~wd;
      default: csr_wval = old_v;
    endcase
  endfunction

  assign w_mstatus    = {19'd0, 2'b11, 3'd0, r_mstatus_mpie, 3'd0, r_mstatus_mie, 3'd0};
  assign w_mstatus_wv = csr_wval(w_mstatus, csr_wdata, csr_wop);
  assign w_mtip       = (r_mtime >= mtimecmp);
  assign w_mip        = {20'd0, meip, 3'd0, w_mtip, 3'd0, msip, 3'd0}
                      | ((32'(plat_irq) << 16) & PLAT_MASK);
  assign w_pend       = w_mip & r_mie;
  assign w_irq_take   = r_mstatus_mie & (|w_pend);
  assign w_trap       = (r_state == ST_RUN) & ~branch_hazard & (exc_valid | w_irq_take);
  assign w_mret       = (r_state == ST_RUN) & mret_valid & ~w_trap;
  assign w_wr_en      = (r_state == ST_RUN) & csr_we & ~w_trap;
  // Vectored mode only offsets interrupts; an exception always wins the trap slot.
  assign w_trap_vec   = {r_mtvec[31:2], 2'b00}
                      + ((r_mtvec[0] & ~exc_valid) ? {25'd0, w_irq_cause, 2'b00} : 32'd0);

  // Fixed-priority interrupt cause: MEI, MSI, MTI, then the lowest platform line.
  always_comb begin
    w_irq_cause = 5'd0;
    if (w_pend[11]) begin
      w_irq_cause = 5'd11;
    end else if (w_pend[3]) begin
      w_irq_cause = 5'd3;
    end else if (w_pend[7]) begin
      w_irq_cause = 5'd7;
    end else begin
      for (int i = 31; i >= 16; i--) begin
        if (w_pend[i]) begin
          w_irq_cause = 5'(i);
        end else begin
          w_irq_cause = w_irq_cause;
        end
      end
    end
  end

  // Combinational CSR read port; unimplemented addresses read zero.
  always_comb begin
    w_rdata = 32'd0;
    case (csr_raddr)
      12'h300: w_rdata = w_mstatus;
      12'h301: w_rdata = MISA_VAL;
      12'h304: w_rdata = r_mie;
      12'h305: w_rdata = r_mtvec;
      12'h340: w_rdata = r_mscratch;
      12'h341: w_rdata = r_mepc;
      12'h342: w_rdata = r_mcause;
      12'h343: w_rdata = r_mtval;
      12'h344: w_rdata = w_mip;
      12'hF14: w_rdata = HART_ID;
`ifdef CSR_COUNTERS_EN
      12'hB00: w_rdata = r_mcycle[31:0];
      12'hB80: w_rdata = r_mcycle[63:32];
      12'hB02: w_rdata = r_minstret[31:0];
      12'hB82: w_rdata = r_minstret[63:32];
`endif
      default: w_rdata = 32'd0;
    endcase
  end

  // Sequential state: timers, CSR writes, then trap/mret so mret owns MIE/MPIE on a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= ST_RUN;
      r_mstatus_mie    <= 1'b0;
      r_mstatus_mpie   <= 1'b0;
      r_mie            <= 32'd0;
      r_mtvec          <= MTVEC_RESET;
      r_mscratch       <= 32'd0;
      r_mepc           <= 32'd0;
      r_mcause         <= 32'd0;
      r_mtval          <= 32'd0;
      r_redirect_pc    <= 32'd0;
      r_redirect_valid <= 1'b0;
      r_mtime          <= 64'd0;
`ifdef CSR_COUNTERS_EN
      r_mcycle         <= 64'd0;
      r_minstret       <= 64'd0;
`endif
    end else begin
      r_mtime <= r_mtime + {63'd0, time_tick};
`ifdef CSR_COUNTERS_EN
      r_mcycle   <= r_mcycle + 64'd1;
      r_minstret <= r_minstret + {63'd0, inst_retire};
`endif
      if (w_wr_en) begin
        case (csr_waddr)
          12'h300: begin
            r_mstatus_mie  <= w_mstatus_wv[3];
            r_mstatus_mpie <= w_mstatus_wv[7];
          end
          12'h304: r_mie      <= csr_wval(r_mie, csr_wdata, csr_wop) & MIE_MASK;
          12'h305: r_mtvec    <= csr_wval(r_mtvec, csr_wdata, csr_wop) & MTVEC_MASK;
          12'h340: r_mscratch <= csr_wval(r_mscratch, csr_wdata, csr_wop);
          12'h341: r_mepc     <= csr_wval(r_mepc, csr_wdata, csr_wop) & MEPC_MASK;
          12'h342: r_mcause   <= csr_wval(r_mcause, csr_wdata, csr_wop);
          12'h343: r_mtval    <= csr_wval(r_mtval, csr_wdata, csr_wop);
`ifdef CSR_COUNTERS_EN
          12'hB00: r_mcycle[31:0]    <= csr_wval(r_mcycle[31:0], csr_wdata, csr_wop);
          12'hB80: r_mcycle[63:32]   <= csr_wval(r_mcycle[63:32], csr_wdata, csr_wop);
          12'hB02: r_minstret[31:0]  <= csr_wval(r_minstret[31:0], csr_wdata, csr_wop);
          12'hB82: r_minstret[63:32] <= csr_wval(r_minstret[63:32], csr_wdata, csr_wop);
`endif
          default: begin
          end
        endcase
      end
      case (r_state)
        ST_RUN: begin
          if (w_trap) begin
            r_mepc           <= (exc_valid ? exc_pc : int_pc) & MEPC_MASK;
            r_mcause         <= exc_valid ? {27'd0, exc_code} : {1'b1, 26'd0, w_irq_cause};
            r_mtval          <= exc_valid ? exc_tval : 32'd0;
            r_mstatus_mpie   <= r_mstatus_mie;
            r_mstatus_mie    <= 1'b0;
            r_redirect_pc    <= w_trap_vec;
            r_redirect_valid <= 1'b1;
            r_state          <= ST_REDIR;
          end else if (w_mret) begin
            r_mstatus_mie    <= r_mstatus_mpie;
            r_mstatus_mpie   <= 1'b1;
            r_redirect_pc    <= r_mepc;
            r_redirect_valid <= 1'b1;
            r_state          <= ST_REDIR;
          end
        end
        ST_REDIR: begin
          if (redirect_ready) begin
            r_redirect_valid <= 1'b0;
            r_state          <= ST_RUN;
          end
        end
        default: begin
          r_redirect_valid <= 1'b0;
          r_state          <= ST_RUN;
        end
      endcase
    end
  end

  assign csr_rdata      = w_rdata;
  assign mtime          = r_mtime;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Self-checking bench for csr_trap_unit (default build, counters disabled).
module tb_csr_trap_unit;
  localparam logic [31:0] TB_HART  = 32'h0000_0005;
  localparam logic [31:0] TB_MTVEC = 32'h0000_0080;
  localparam logic [31:0] MISA     = 32'h4000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] csr_raddr, csr_waddr;
  logic [31:0] csr_rdata, csr_wdata;
  logic        csr_we;
  logic [1:0]  csr_wop;
  logic        exc_valid, branch_hazard, mret_valid, meip, msip, time_tick;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc, exc_tval, int_pc, redirect_pc;
  logic [3:0]  plat_irq;
  logic [63:0] mtimecmp, mtime;
  logic        redirect_valid, redirect_ready;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_val [int];
  logic [63:0] m_mtime;

  always #5 clk = ~clk;

  csr_trap_unit #(.XLEN(32), .NUM_PLAT_IRQ(4), .HART_ID(TB_HART), .MTVEC_RESET(TB_MTVEC)) dut (
    .clk(clk), .rst(rst), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_we(csr_we),
    .csr_waddr(csr_waddr), .csr_wop(csr_wop), .csr_wdata(csr_wdata), .exc_valid(exc_valid),
    .exc_code(exc_code), .exc_pc(exc_pc), .exc_tval(exc_tval), .int_pc(int_pc),
    .branch_hazard(branch_hazard), .mret_valid(mret_valid), .meip(meip), .msip(msip),
    .plat_irq(plat_irq), .mtimecmp(mtimecmp), .time_tick(time_tick), .mtime(mtime),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    csr_we = 1'b0; csr_wop = 2'b00; csr_waddr = 12'h000; csr_wdata = 32'h0;
    exc_valid = 1'b0; exc_code = 5'd0; exc_pc = 32'h0; exc_tval = 32'h0;
    mret_valid = 1'b0; branch_hazard = 1'b0; redirect_ready = 1'b0; time_tick = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    csr_raddr = 12'h000; int_pc = 32'h0; meip = 1'b0; msip = 1'b0; plat_irq = 4'h0;
    mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    csr_we = 1'b1; csr_waddr = a; csr_wop = op; csr_wdata = d;
    tick();
    csr_we = 1'b0; csr_wop = 2'b00;
  endtask

  task automatic csr_rd(input logic [11:0] a, output logic [31:0] d);
    csr_raddr = a; #1; d = csr_rdata;
  endtask

  task automatic wait_redir(input int limit, output int cycles);
    cycles = 0;
    while (!redirect_valid && cycles < limit) begin
      tick(); cycles++;
    end
  endtask

  // Architectural mstatus image: MPP always 11, MIE at bit 3, MPIE at bit 7.
  function automatic logic [31:0] mstat(input logic mie, input logic mpie);
    return 32'h0000_1800 | (mie ? 32'h8 : 32'h0) | (mpie ? 32'h80 : 32'h0);
  endfunction

  // Writable-bit mask of each implemented CSR.
  function automatic logic [31:0] m_mask(input int a);
    case (a)
      'h300:               return 32'h0000_0088;
      'h304:               return 32'h000F_0888;
      'h305:               return 32'hFFFF_FFFD;
      'h341:               return 32'hFFFF_FFFC;
      'h340, 'h342, 'h343: return 32'hFFFF_FFFF;
      default:             return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input int a);
    return m_val.exists(a) ? m_val[a] : 32'h0;
  endfunction

  task automatic m_write(input int a, input logic [1:0] op, input logic [31:0] wd);
    logic [31:0] old_v, nv;
    if (m_val.exists(a) && op != 2'b00) begin
      old_v = m_val[a];
      nv = (op == 2'b01) ? wd : (op == 2'b10) ? (old_v | wd) : (old_v & ~wd);
      m_val[a] = (old_v & ~m_mask(a)) | (nv & m_mask(a));
    end
  endtask

  task automatic m_init();
    m_val.delete();
    m_val['h300] = 32'h0000_1800; m_val['h301] = MISA; m_val['h304] = 32'h0;
    m_val['h305] = TB_MTVEC; m_val['h340] = 32'h0; m_val['h341] = 32'h0;
    m_val['h342] = 32'h0; m_val['h343] = 32'h0; m_val['h344] = 32'h0;
    m_val['hF11] = 32'h0; m_val['hF12] = 32'h0; m_val['hF13] = 32'h0; m_val['hF14] = TB_HART;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", redirect_valid); end
    n_tests++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", redirect_pc); end
    n_tests++; if (mtime !== 64'h0) begin n_fail++; $display("FAIL reset_mtime: got %h want 0", mtime); end
    csr_rd(12'h305, d);
    n_tests++; if (d !== TB_MTVEC) begin n_fail++; $display("FAIL reset_mtvec: got %h want %h", d, TB_MTVEC); end
    csr_rd(12'h300, d);
    n_tests++; if (d !== mstat(1'b0, 1'b0)) begin n_fail++; $display("FAIL reset_mstatus: got %h want %h", d, mstat(1'b0, 1'b0)); end
    csr_rd(12'hF14, d);
    n_tests++; if (d !== TB_HART) begin n_fail++; $display("FAIL mhartid: got %h want %h", d, TB_HART); end
    csr_wr(12'h300, 2'b01, 32'h88); csr_rd(12'h300, d);
    n_tests++; if (d !== mstat(1'b1, 1'b1)) begin n_fail++; $display("FAIL mstatus_write: got %h want %h", d, mstat(1'b1, 1'b1)); end
    csr_wr(12'h300, 2'b11, 32'h8); csr_rd(12'h300, d);
    n_tests++; if (d !== mstat(1'b0, 1'b1)) begin n_fail++; $display("FAIL mstatus_clear: got %h want %h", d, mstat(1'b0, 1'b1)); end
  endtask

  task automatic test_exception();
    logic [31:0] d;
    do_reset();
    csr_wr(12'h305, 2'b01, 32'h100);
    csr_wr(12'h300, 2'b01, 32'h8);
    exc_valid = 1'b1; exc_code = 5'd2; exc_pc = 32'h40; exc_tval = 32'hDEAD;
    tick(); exc_valid = 1'b0;
    n_tests++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL exc_valid_out: got %b want 1", redirect_valid); end
    n_tests++; if (redirect_pc !== 32'h100) begin n_fail++; $display("FAIL exc_pc_out: got %h want 100", redirect_pc); end
    csr_rd(12'h342, d);
    n_tests++; if (d !== 32'h2) begin n_fail++; $display("FAIL exc_mcause: got %h want 2", d); end
    csr_rd(12'h341, d);
    n_tests++; if (d !== 32'h40) begin n_fail++; $display("FAIL exc_mepc: got %h want 40", d); end
    csr_rd(12'h343, d);
    n_tests++; if (d !== 32'hDEAD) begin n_fail++; $display("FAIL exc_mtval: got %h want dead", d); end
    csr_rd(12'h300, d);
    n_tests++; if (d !== mstat(1'b0, 1'b1)) begin n_fail++; $display("FAIL exc_mstatus: got %h want %h", d, mstat(1'b0, 1'b1)); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h100) begin n_fail++; $display("FAIL exc_hold%0d: got %b/%h want 1/100", i, redirect_valid, redirect_pc); end
    end
    redirect_ready = 1'b1; tick(); redirect_ready = 1'b0;
    n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL exc_release: got %b want 0", redirect_valid); end
  endtask

  task automatic test_timer_irq();
    logic [31:0] d;
    int cyc;
    do_reset();
    csr_wr(12'h305, 2'b01, 32'h101);
    csr_wr(12'h304, 2'b01, 32'h80);
    mtimecmp = 64'd5; int_pc = 32'h0000_4A5C;
    csr_wr(12'h300, 2'b01, 32'h8);
    time_tick = 1'b1;
    wait_redir(20, cyc);
    time_tick = 1'b0;
    n_tests++; if (redirect_valid !== 1'b1 || cyc != 6) begin n_fail++; $display("FAIL tmr_latency: got valid=%b after %0d want 1 after 6", redirect_valid, cyc); end
    n_tests++; if (redirect_pc !== 32'h11C) begin n_fail++; $display("FAIL tmr_vector: got %h want 11c", redirect_pc); end
    n_tests++; if (mtime !== 64'd6) begin n_fail++; $display("FAIL tmr_mtime: got %0d want 6", mtime); end
    csr_rd(12'h342, d);
    n_tests++; if (d !== 32'h8000_0007) begin n_fail++; $display("FAIL tmr_mcause: got %h want 80000007", d); end
    csr_rd(12'h341, d);
    n_tests++; if (d !== int_pc) begin n_fail++; $display("FAIL tmr_mepc: got %h want %h", d, int_pc); end
    csr_rd(12'h343, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL tmr_mtval: got %h want 0", d); end
    redirect_ready = 1'b1; tick(); redirect_ready = 1'b0;
  endtask

  task automatic test_priority();
    logic [31:0] d;
    int cyc;
    int causes [3] = '{11, 3, 16};
    do_reset();
    csr_wr(12'h305, 2'b01, 32'h200);
    csr_wr(12'h304, 2'b01, 32'h0001_0888);
    int_pc = 32'h0000_0600; meip = 1'b1; msip = 1'b1; plat_irq = 4'b0001;
    csr_wr(12'h300, 2'b01, 32'h8);
    for (int k = 0; k < 3; k++) begin
      wait_redir(10, cyc);
      n_tests++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL prio_wait%0d: got 0 want 1", k); end
      csr_rd(12'h342, d);
      n_tests++; if (d !== (32'h8000_0000 | 32'(causes[k]))) begin n_fail++; $display("FAIL prio_cause%0d: got %h want %h", k, d, 32'h8000_0000 | 32'(causes[k])); end
      redirect_ready = 1'b1; tick(); redirect_ready = 1'b0;
      if (k == 0) meip = 1'b0; else if (k == 1) msip = 1'b0; else plat_irq = 4'b0000;
      mret_valid = 1'b1; tick(); mret_valid = 1'b0;
      n_tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h600) begin n_fail++; $display("FAIL prio_mret%0d: got %b/%h want 1/600", k, redirect_valid, redirect_pc); end
      redirect_ready = 1'b1; tick(); redirect_ready = 1'b0;
    end
  endtask

  task automatic test_hazard_collision();
    logic [31:0] d;
    do_reset();
    csr_wr(12'h305, 2'b01, 32'h300);
    csr_wr(12'h304, 2'b01, 32'h8);
    csr_wr(12'h340, 2'b01, 32'h1111);
    int_pc = 32'h0000_0A00; msip = 1'b1; branch_hazard = 1'b1;
    csr_wr(12'h300, 2'b01, 32'h8);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL hazard_block%0d: got %b want 0", i, redirect_valid); end
    end
    branch_hazard = 1'b0; tick();
    n_tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h300) begin n_fail++; $display("FAIL hazard_entry: got %b/%h want 1/300", redirect_valid, redirect_pc); end
    csr_rd(12'h342, d);
    n_tests++; if (d !== 32'h8000_0003) begin n_fail++; $display("FAIL hazard_cause: got %h want 80000003", d); end
    msip = 1'b0; redirect_ready = 1'b1; tick(); redirect_ready = 1'b0;
    exc_valid = 1'b1; exc_code = 5'd5; exc_pc = 32'h88; exc_tval = 32'h77; mret_valid = 1'b1;
    csr_we = 1'b1; csr_waddr = 12'h340; csr_wop = 2'b01; csr_wdata = 32'h2222;
    tick(); idle();
    n_tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h300) begin n_fail++; $display("FAIL coll_trap: got %b/%h want 1/300", redirect_valid, redirect_pc); end
    csr_rd(12'h340, d);
    n_tests++; if (d !== 32'h1111) begin n_fail++; $display("FAIL coll_mscratch: got %h want 1111", d); end
    csr_rd(12'h341, d);
    n_tests++; if (d !== 32'h88) begin n_fail++; $display("FAIL coll_mepc: got %h want 88", d); end
    redirect_ready = 1'b1; tick(); redirect_ready = 1'b0;
  endtask

  task automatic test_mret();
    logic [31:0] d;
    do_reset();
    csr_wr(12'h341, 2'b01, 32'h200);
    csr_wr(12'h300, 2'b01, 32'h80);
    mret_valid = 1'b1; tick(); mret_valid = 1'b0;
    n_tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h200) begin n_fail++; $display("FAIL mret_redirect: got %b/%h want 1/200", redirect_valid, redirect_pc); end
    csr_rd(12'h300, d);
    n_tests++; if (d !== mstat(1'b1, 1'b1)) begin n_fail++; $display("FAIL mret_mstatus: got %h want %h", d, mstat(1'b1, 1'b1)); end
    redirect_ready = 1'b1; tick(); redirect_ready = 1'b0;
    csr_wr(12'h300, 2'b01, 32'h80);
    mret_valid = 1'b1; csr_we = 1'b1; csr_waddr = 12'h300; csr_wop = 2'b01; csr_wdata = 32'h0;
    tick(); idle();
    csr_rd(12'h300, d);
    n_tests++; if (d !== mstat(1'b1, 1'b1)) begin n_fail++; $display("FAIL mret_vs_write: got %h want %h", d, mstat(1'b1, 1'b1)); end
    redirect_ready = 1'b1; tick(); redirect_ready = 1'b0;
    mret_valid = 1'b1; csr_we = 1'b1; csr_waddr = 12'h340; csr_wop = 2'b01; csr_wdata = 32'hABCD;
    tick(); idle();
    csr_rd(12'h340, d);
    n_tests++; if (d !== 32'hABCD || redirect_valid !== 1'b1) begin n_fail++; $display("FAIL mret_plus_write: got %h/%b want abcd/1", d, redirect_valid); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_tests++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin n_fail++; $display("FAIL redir_reset: got %b/%h want 0/0", redirect_valid, redirect_pc); end
    csr_rd(12'h340, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL redir_reset_mscratch: got %h want 0", d); end
  endtask

  task automatic test_random_csr();
    int addr_list [16] = '{'h300, 'h301, 'h304, 'h305, 'h340, 'h341, 'h342, 'h343,
                           'h344, 'hF11, 'hF12, 'hF13, 'hF14, 'hB00, 'hB02, 'h7C0};
    int a;
    logic [1:0]  op;
    logic [31:0] wd;
    logic        tt;
    do_reset();
    m_init(); m_mtime = 64'd0;
    for (int it = 0; it < 80; it++) begin
      a = addr_list[$urandom_range(0, 15)];
      op = 2'($urandom_range(0, 3)); wd = $urandom(); tt = 1'($urandom_range(0, 1));
      csr_raddr = 12'(a); csr_waddr = 12'(a); csr_we = 1'b1; csr_wop = op; csr_wdata = wd;
      time_tick = tt;
      #1;
      n_tests++; if (csr_rdata !== m_read(a)) begin n_fail++; $display("FAIL rnd_pre it%0d addr %h: got %h want %h", it, a, csr_rdata, m_read(a)); end
      tick();
      csr_we = 1'b0; time_tick = 1'b0;
      m_write(a, op, wd);
      m_mtime = m_mtime + 64'(tt);
      #1;
      n_tests++; if (csr_rdata !== m_read(a)) begin n_fail++; $display("FAIL rnd_post it%0d addr %h op %0d: got %h want %h", it, a, op, csr_rdata, m_read(a)); end
      n_tests++; if (mtime !== m_mtime) begin n_fail++; $display("FAIL rnd_mtime it%0d: got %0d want %0d", it, mtime, m_mtime); end
    end
  endtask

  initial begin
    test_reset();
    test_exception();
    test_timer_irq();
    test_priority();
    test_hazard_collision();
    test_mret();
    test_random_csr();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
